// File: rtl/r8_booth_pp_pipe.sv
// Pipelined radix-8 Booth partial-product generator with per-digit encode/select lanes.
// Optional S2 output register controlled by macro R8_PP_OUT_REG_EN.

module r8_booth_digit #(
   parameter int PPW = 27
) (
   input  logic [3:0]     trip,
   input  logic [PPW-1:0] m1,
   input  logic [PPW-1:0] m2,
   input  logic [PPW-1:0] m3,
   input  logic [PPW-1:0] m4,
   output logic [4:0]     beu,
   output logic [PPW-1:0] bsu
);
   logic [PPW-1:0] sel;

   // trip = {y[3i+2], y[3i+1], y[3i], y[3i-1]}; beu = {neg, sel4, sel3, sel2, sel1}
   always_comb begin
      beu = 5'b00000;
      unique case (trip)
         4'b0000, 4'b1111: beu = 5'b00000;
         4'b0001, 4'b0010: beu = 5'b00001;
         4'b0011, 4'b0100: beu = 5'b00010;
         4'b0101, 4'b0110: beu = 5'b00100;
         4'b0111:          beu = 5'b01000;
         4'b1000:          beu = 5'b11000;
         4'b1001, 4'b1010: beu = 5'b10100;
         4'b1011, 4'b1100: beu = 5'b10010;
         4'b1101, 4'b1110: beu = 5'b10001;
         default:          beu = 5'b00000;
      endcase
   end

   always_comb begin
      sel = '0;
      if (beu[3])      sel = m4;
      else if (beu[2]) sel = m3;
      else if (beu[1]) sel = m2;
      else if (beu[0]) sel = m1;
      bsu = beu[4] ? ~sel : sel;
   end
endmodule

module r8_booth_pp_pipe #(
   parameter  int W   = 24,
   localparam int NPP = W / 3 + 1,
   localparam int PPW = W + 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      signed_mode,
   input  logic [W-1:0]              x_in,
   input  logic [W-1:0]              y_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NPP-1:0][4:0]       beu_out,
   output logic [NPP-1:0][PPW-1:0]   bsu_out
);
   localparam int YW = 3 * NPP;

   logic                     s1_valid;
   logic                     s1_mode;
   logic [PPW-1:0]           s1_x;
   logic [W-1:0]             s1_y;
   logic                     s1_adv;
   logic [PPW-1:0]           x_ext_in;
   logic [YW:0]              y_ext;
   logic [PPW-1:0]           m1, m2, m3, m4;
   logic [NPP-1:0][4:0]      beu_c;
   logic [NPP-1:0][PPW-1:0]  bsu_c;

   assign x_ext_in = signed_mode ? {{3{x_in[W-1]}}, x_in} : {3'b000, x_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mode <= signed_mode;
            s1_x    <= x_ext_in;
            s1_y    <= y_in;
         end
      end
   end

   // bit 0 is y[-1]; the three top bits make the last digit 0 (signed) or y[W-1] (unsigned)
   assign y_ext = {{3{s1_mode & s1_y[W-1]}}, s1_y, 1'b0};

   assign m1 = s1_x;
   assign m2 = {s1_x[PPW-2:0], 1'b0};
   assign m4 = {s1_x[PPW-3:0], 2'b00};
   assign m3 = m1 + m2;

   for (genvar i = 0; i < NPP; i++) begin : g_lane
      r8_booth_digit #(.PPW(PPW)) u_digit (
         .trip (y_ext[3*i+3 -: 4]),
         .m1   (m1),
         .m2   (m2),
         .m3   (m3),
         .m4   (m4),
         .beu  (beu_c[i]),
         .bsu  (bsu_c[i])
      );
   end

`ifdef R8_PP_OUT_REG_EN
   logic s2_adv;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         beu_out   <= '0;
         bsu_out   <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            beu_out <= beu_c;
            bsu_out <= bsu_c;
         end
      end
   end
`else
   assign s1_adv    = !s1_valid || out_ready;
   assign in_ready  = s1_adv;
   assign out_valid = s1_valid;
   assign beu_out   = beu_c;
   assign bsu_out   = bsu_c;
`endif
endmodule

// File: tb/tb_r8_booth_pp_pipe.sv
// Directed self-checking bench for r8_booth_pp_pipe (W=24), both output-register builds.
module tb_r8_booth_pp_pipe;
   localparam int W   = 24;
   localparam int NPP = W / 3 + 1;
   localparam int PPW = W + 3;
`ifdef R8_PP_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic                     signed_mode = 1'b0;
   logic [W-1:0]             x_in = '0;
   logic [W-1:0]             y_in = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b1;
   logic [NPP-1:0][4:0]      beu_out;
   logic [NPP-1:0][PPW-1:0]  bsu_out;

   logic [NPP-1:0][4:0]      e_beu;
   logic [NPP-1:0][PPW-1:0]  e_bsu;
   int n_chk = 0;
   int n_fail = 0;

   r8_booth_pp_pipe #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .signed_mode(signed_mode), .x_in(x_in), .y_in(y_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .beu_out(beu_out), .bsu_out(bsu_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_pp(input string tag);
      for (int i = 0; i < NPP; i++) begin
         check($sformatf("%s_beu%0d", tag, i), 32'(beu_out[i]), 32'(e_beu[i]));
         check($sformatf("%s_bsu%0d", tag, i), 32'(bsu_out[i]), 32'(e_bsu[i]));
      end
   endtask

   // single transaction with out_ready high; compares against e_beu/e_bsu
   task automatic run_one(input string tag, input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
      int lat;
      @(negedge clk);
      signed_mode = sm; x_in = x; y_in = y; in_valid = 1'b1; out_ready = 1'b1;
      #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(LAT));
      check_pp(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, rcv, first_c, last_c;
      logic rdy;
      logic [W-1:0] bx [3];

      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_beu", 32'(|beu_out), 32'd0);
      check("rst_bsu", 32'(|bsu_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_in_ready", 32'(in_ready), 32'd1);

      // x=1, y=7 unsigned: digit0 = -1, digit1 = +1
      e_beu = '0; e_bsu = '0;
      e_beu[0] = 5'b10001; e_bsu[0] = 27'h7FFFFFE;
      e_beu[1] = 5'b00001; e_bsu[1] = 27'd1;
      run_one("t1", 1'b0, 24'd1, 24'h000007);

      // x=5, y=3: digit0 = +3 exercises the 3x adder
      e_beu = '0; e_bsu = '0;
      e_beu[0] = 5'b00100; e_bsu[0] = 27'd15;
      run_one("t2", 1'b0, 24'd5, 24'd3);

      // y all ones: signed gives -1, unsigned adds a top digit of +1
      e_beu = '0; e_bsu = '0;
      e_beu[0] = 5'b10001; e_bsu[0] = 27'h7FFFFFE;
      run_one("t3s", 1'b1, 24'd1, 24'hFFFFFF);
      e_beu[8] = 5'b00001; e_bsu[8] = 27'd1;
      run_one("t3u", 1'b0, 24'd1, 24'hFFFFFF);

      // signed x=-2^23, y=4: digit0 = -4, digit1 = +1 (from y[2])
      e_beu = '0; e_bsu = '0;
      e_beu[0] = 5'b11000; e_bsu[0] = 27'h1FFFFFF;
      e_beu[1] = 5'b00001; e_bsu[1] = 27'h7800000;
      run_one("t4", 1'b1, 24'h800000, 24'd4);

      // x=7, y=5 unsigned: digit0 = -3 -> ~21, digit1 = +1
      e_beu = '0; e_bsu = '0;
      e_beu[0] = 5'b10100; e_bsu[0] = 27'h7FFFFEA;
      e_beu[1] = 5'b00001; e_bsu[1] = 27'd7;
      run_one("t7", 1'b0, 24'd7, 24'd5);

      // backpressure: three pairs (x=1,2,3 ; y=1), outputs held until release
      bx[0] = 24'd1; bx[1] = 24'd2; bx[2] = 24'd3;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         out_ready = 1'b0; signed_mode = 1'b0; y_in = 24'd1;
         in_valid = (idx < 3);
         x_in = bx[idx < 3 ? idx : 2];
         #1;
         if (out_valid) begin
            check("bp_hold_beu", 32'(beu_out[0]), 32'h01);
            check("bp_hold_bsu", 32'(bsu_out[0]), 32'd1);
         end
         rdy = in_ready;
         @(posedge clk);
         if (rdy && in_valid) idx++;
      end
      check("bp_accepts", 32'(idx), 32'(LAT));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      rcv = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 12 && rcv < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid = (idx < 3);
         x_in = bx[idx < 3 ? idx : 2];
         #1;
         if (out_valid) begin
            check($sformatf("bp_out%0d_beu", rcv), 32'(beu_out[0]), 32'h01);
            check($sformatf("bp_out%0d_bsu", rcv), 32'(bsu_out[0]), 32'(bx[rcv]));
            if (first_c < 0) first_c = c;
            last_c = c;
            rcv++;
         end
         rdy = in_ready;
         @(posedge clk);
         if (rdy && in_valid) idx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_count", 32'(rcv), 32'd3);
      check("bp_span", 32'(last_c - first_c), 32'd2);

      // reset with pipeline full and stalled
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; signed_mode = 1'b0;
         x_in = 24'd9; y_in = 24'd7;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_beu", 32'(|beu_out), 32'd0);
      check("mid_rst_bsu", 32'(|bsu_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      e_beu = '0; e_bsu = '0;
      e_beu[0] = 5'b00100; e_bsu[0] = 27'd15;
      run_one("t6", 1'b0, 24'd5, 24'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/r8_booth_pp_pipe.md
Name: r8_booth_pp_pipe

Overview:
Parametrised, pipelined radix-8 Modified Booth partial-product generator. Takes a multiplicand x and multiplier y through a valid/ready handshake and produces all NPP Booth digit encodings and selected, conditionally inverted partial products. It computes the hard multiple 3x internally. The output feeds the Dadda reduction tree. Runtime mode selects signed or unsigned operands.

Parameters:
W, 24, operand width of x and y; must be a multiple of 3, minimum 6
NPP, W/3+1, number of partial products (derived, not overridable)
PPW, W+3, partial-product width, wide enough for unsigned 4x plus sign

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
signed_mode  in  1  1 = two's-complement x,y; 0 = unsigned; sampled with operands
x_in  in  W  multiplicand
y_in  in  W  multiplier
out_valid  out  1  outputs valid
out_ready  in  1  downstream accepts outputs
beu_out  out  NPP x 5  per-digit encoding {neg, sel4, sel3, sel2, sel1}
bsu_out  out  NPP x PPW  per-digit selected multiple, one's-complemented when neg=1

Behaviour:
- Reset (async, rst_n=0): all valid flags 0, out_valid=0, beu_out=0, bsu_out=0, in_ready=1 once rst_n=1.
- Extension: y is extended to 3*NPP bits with y[-1]=0. The extension uses y[W-1] when signed_mode=1 and 0 otherwise. x is sign- or zero-extended to PPW before the multiples are formed.
- Digit i: d = -4*y[3i+2] + 2*y[3i+1] + y[3i] + y[3i-1], with range -4..+4.
- Encoding: neg = (d<0). Exactly one of sel4/sel3/sel2/sel1 is set for |d| = 4/3/2/1. d=0, including triplet 111 with y[3i-1]=1, gives 00000.
- Multiples: 1x, 2x = x<<1, 4x = x<<2, 3x = x + 2x via a full PPW adder. All are PPW-bit.
- bsu_out[i] = selected multiple, bitwise inverted if neg=1, or 0 if d=0. The +1 for negation is carried by beu_out[i][4] and injected later by the tree.
- Signed mode: the top digit is always 0. Unsigned mode: the top digit equals y[W-1] (0 or +1).
- Pipeline stage S1 registers x_ext, y_ext and mode on in_valid && in_ready. 3x and encoding are computed between S1 and S2. S2 registers beu_out/bsu_out.
- Latency: 2 cycles from accept to out_valid. Throughput is 1 per cycle with out_ready held high.
- Stall rules:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = !s1_valid || S2 advances (combinational from out_ready).
- While out_valid && !out_ready, beu_out/bsu_out/out_valid hold stable. No data is lost or duplicated, and order is preserved.
- Simultaneous accept and emit in one cycle is legal and keeps the pipeline full.
- Reset mid-operation discards all in-flight operands immediately.

Optional Feature:
R8_PP_OUT_REG_EN:
- Defined: S2 output register present, latency 2, stall rules as above.
- Undefined: S2 removed. beu_out/bsu_out are combinational from S1, out_valid = s1_valid, in_ready = !s1_valid || out_ready, latency 1.
- Encoding and arithmetic are identical in both builds.

Test Plan:
1. W=24, unsigned, x=1, y=0x000007 -> beu[0]=10001, bsu[0]=all ones except bit0=0; beu[1]=00001, bsu[1]=1; beu[2..8]=0; out_valid 2 cycles after accept.
2. Unsigned, x=5, y=3 -> beu[0]=00100, bsu[0]=15; all other digits zero.
3. y=0xFFFFFF, x=1:
   - signed_mode=1 -> beu[0]=10001, beu[1..8]=0.
   - signed_mode=0 -> beu[0]=10001, beu[1..7]=0, beu[8]=00001, bsu[8]=1.
4. Signed, x=0x800000, y=4 -> beu[0]=11000, bsu[0]=0x1FFFFFF (inverted -2^25 in 27 bits); beu[8]=0.
5. Backpressure: issue 3 back-to-back pairs with out_ready=0 -> in_ready drops after 2 accepts; outputs hold the first result. Release out_ready -> 3 results emerge in order, one per cycle.
6. Pull rst_n low while out_valid=1 and S1 full -> out_valid=0 and outputs=0 immediately; in_ready=1 after release; the next operand produces a correct result with latency 2.
